// File: rtl/background_fill_pkg.sv
// Shared constants, widths and FSM encoding for the background RAM fill engine.
package background_fill_pkg;

    localparam int NUMBER_COLORS = 10;
    localparam int WIDTH         = 320;
    localparam int HEIGHT        = 240;

    localparam int CW = $clog2(NUMBER_COLORS) + 1;
    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam int XW = 9;
    localparam int YW = 8;

    localparam logic [XW-1:0] X_MAX    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(HEIGHT - 1);
    localparam logic [AW-1:0] COL_STEP = AW'(HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        DONE
    } fill_state_t;

    // Column-major RAM address; only used once per command, in SETUP.
    function automatic logic [AW-1:0] pixel_addr(
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        return AW'(y) + AW'(x) * COL_STEP;
    endfunction

endpackage

// File: rtl/bg_fill_addr_gen.sv
// Rectangle walker: y fastest, x outer, column-major address kept incrementally.
module bg_fill_addr_gen
    import background_fill_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [XW-1:0] x;
    logic [XW-1:0] x_hi;
    logic [YW-1:0] y;
    logic [YW-1:0] y_lo;
    logic [YW-1:0] y_hi;
    logic [AW-1:0] col_base;
    logic          col_end;

    assign col_end = (y == y_hi);
    assign last    = col_end && (x == x_hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            x_hi     <= '0;
            y        <= '0;
            y_lo     <= '0;
            y_hi     <= '0;
            col_base <= '0;
            addr     <= '0;
        end else begin
            unique case (1'b1)
                load: begin
                    x        <= x0;
                    x_hi     <= x1;
                    y        <= y0;
                    y_lo     <= y0;
                    y_hi     <= y1;
                    col_base <= base;
                    addr     <= base;
                end
                step && !col_end: begin
                    y    <= y + 1'b1;
                    addr <= addr + 1'b1;
                end
                // Next column starts one full column past this one's start.
                step && col_end: begin
                    x        <= x + 1'b1;
                    y        <= y_lo;
                    col_base <= col_base + COL_STEP;
                    addr     <= col_base + COL_STEP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/background_fill.sv
// Rectangle-fill write engine for the background frame RAM write port.
module background_fill
    import background_fill_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x0,
    input  logic [YW-1:0] cmd_y0,
    input  logic [XW-1:0] cmd_x1,
    input  logic [YW-1:0] cmd_y1,
    input  logic [CW-1:0] cmd_color,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [CW-1:0] din,
    output logic          busy,
    output logic          done
);

    fill_state_t   state;
    logic [XW-1:0] x0_q;
    logic [XW-1:0] x1_q;
    logic [YW-1:0] y0_q;
    logic [YW-1:0] y1_q;
    logic [CW-1:0] color_q;

    logic [XW-1:0] x1c;
    logic [YW-1:0] y1c;
    logic [AW-1:0] base;
    logic          empty;
    logic          gen_load;
    logic          gen_step;
    logic          gen_last;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == SETUP) || (state == FILL);

    assign x1c   = (x1_q > X_MAX) ? X_MAX : x1_q;
    assign y1c   = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    assign empty = (x0_q > x1c) || (y0_q > y1c) ||
                   (x0_q > X_MAX) || (y0_q > Y_MAX);
    assign base  = pixel_addr(x0_q, y0_q);

    assign gen_load = (state == SETUP) && !empty;
    assign gen_step = (state == FILL) && !gen_last;

    bg_fill_addr_gen u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (gen_load),
        .step  (gen_step),
        .base  (base),
        .x0    (x0_q),
        .x1    (x1c),
        .y0    (y0_q),
        .y1    (y1c),
        .addr  (waddr),
        .last  (gen_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            we      <= 1'b0;
            din     <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid) begin
                        x0_q    <= cmd_x0;
                        x1_q    <= cmd_x1;
                        y0_q    <= cmd_y0;
                        y1_q    <= cmd_y1;
                        color_q <= cmd_color;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (empty) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        we    <= 1'b1;
                        din   <= color_q;
                        state <= FILL;
                    end
                end
                // we stays high; the walker advances until the last pixel is out.
                FILL: begin
                    if (gen_last) begin
                        we    <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_background_fill.sv
// Directed table-driven bench for background_fill with a RAM model.
module tb_background_fill;
    import background_fill_pkg::*;

    typedef struct {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
        logic [CW-1:0] color;
    } cmd_t;

    typedef struct {
        cmd_t c;
        int   n;
        int   first;
        int   last_a;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [XW-1:0] cmd_x0;
    logic [YW-1:0] cmd_y0;
    logic [XW-1:0] cmd_x1;
    logic [YW-1:0] cmd_y1;
    logic [CW-1:0] cmd_color;
    logic          we;
    logic [AW-1:0] waddr;
    logic [CW-1:0] din;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int            wr_addr_q[$];
    int            wr_cyc_q[$];
    logic [CW-1:0] wr_din_q[$];
    int            done_cyc_q[$];
    logic [CW-1:0] ram [WIDTH*HEIGHT];

    vec_t vecs[10];

    background_fill dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .we        (we),
        .waddr     (waddr),
        .din       (din),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (we) begin
                wr_addr_q.push_back(int'(waddr));
                wr_cyc_q.push_back(cyc);
                wr_din_q.push_back(din);
                if (int'(waddr) < WIDTH * HEIGHT) ram[waddr] = din;
            end
            if (done) done_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int x0, input int y0, input int x1,
                                input int y1, input int col, input int n,
                                input int first, input int last_a);
        vec_t v;
        v.c.x0    = XW'(x0);
        v.c.y0    = YW'(y0);
        v.c.x1    = XW'(x1);
        v.c.y1    = YW'(y1);
        v.c.color = CW'(col);
        v.n       = n;
        v.first   = first;
        v.last_a  = last_a;
        return v;
    endfunction

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_cyc_q.delete();
        wr_din_q.delete();
        done_cyc_q.delete();
    endtask

    // Presents a command and returns the cycle count seen just before the accept edge.
    task automatic issue(input cmd_t c, output int neg);
        int n;
        n = 0;
        cmd_x0    = c.x0;
        cmd_y0    = c.y0;
        cmd_x1    = c.x1;
        cmd_y1    = c.y1;
        cmd_color = c.color;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 0, 1);
        neg = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int bound);
        int n;
        n = 0;
        while (done_cyc_q.size() < target && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cyc_q.size() < target) chk("done_timeout", 0, 1);
    endtask

    task automatic run_cmd(input cmd_t c, output int neg);
        clear_logs();
        issue(c, neg);
        cmd_valid = 1'b0;
        chk("setup_busy", int'(busy), 1);
        chk("setup_ready", int'(cmd_ready), 0);
        cmd_x0    = 9'd77;
        cmd_y0    = 8'd33;
        cmd_x1    = 9'd1;
        cmd_y1    = 8'd2;
        cmd_color = CW'(21);
        wait_done(1, 100000);
        if (done_cyc_q.size() >= 1) begin
            chk("done_hi", int'(done), 1);
            chk("done_ready_lo", int'(cmd_ready), 0);
            @(negedge clk);
            #1;
            chk("after_done_lo", int'(done), 0);
            chk("after_done_ready", int'(cmd_ready), 1);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_vec(input vec_t v, input int neg, input string tag);
        int xe;
        int ye;
        int k;
        int bad;
        xe = (int'(v.c.x1) > WIDTH - 1) ? WIDTH - 1 : int'(v.c.x1);
        ye = (int'(v.c.y1) > HEIGHT - 1) ? HEIGHT - 1 : int'(v.c.y1);
        chk({tag, "_nwrites"}, wr_addr_q.size(), v.n);
        chk({tag, "_ndone"}, done_cyc_q.size(), 1);
        if (done_cyc_q.size() >= 1)
            chk({tag, "_done_cyc"}, done_cyc_q[0] - neg, 2 + v.n);
        if (v.n > 0 && wr_addr_q.size() == v.n) begin
            chk({tag, "_first_cyc"}, wr_cyc_q[0] - neg, 2);
            chk({tag, "_last_cyc"}, wr_cyc_q[v.n-1] - neg, 1 + v.n);
            chk({tag, "_first_addr"}, wr_addr_q[0], v.first);
            chk({tag, "_last_addr"}, wr_addr_q[v.n-1], v.last_a);
            bad = 0;
            k = 0;
            for (int xx = int'(v.c.x0); xx <= xe; xx++) begin
                for (int yy = int'(v.c.y0); yy <= ye; yy++) begin
                    if (wr_addr_q[k] != yy + HEIGHT * xx) bad++;
                    if (wr_din_q[k] != v.c.color) bad++;
                    k++;
                end
            end
            chk({tag, "_seq"}, bad, 0);
        end
    endtask

    initial begin
        int   neg;
        int   d;
        int   bad;
        int   ex;
        cmd_t c;

        vecs[0] = mk(0, 0, 0, 0, 3, 1, 0, 0);
        vecs[1] = mk(1, 10, 2, 12, 7, 6, 250, 492);
        vecs[2] = mk(318, 238, 400, 255, 9, 4, 76558, 76799);
        vecs[3] = mk(5, 0, 4, 10, 1, 0, 0, 0);
        vecs[4] = mk(0, 5, 3, 4, 2, 0, 0, 0);
        vecs[5] = mk(320, 0, 330, 5, 4, 0, 0, 0);
        vecs[6] = mk(0, 240, 5, 250, 4, 0, 0, 0);
        vecs[7] = mk(319, 0, 319, 239, 15, 240, 76560, 76799);
        vecs[8] = mk(7, 100, 9, 100, 6, 3, 1780, 2260);
        vecs[9] = mk(2, 230, 4, 239, 12, 30, 710, 1199);

        for (int i = 0; i < WIDTH * HEIGHT; i++) ram[i] = '0;

        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_x0    = 9'd3;
        cmd_y0    = 8'd3;
        cmd_x1    = 9'd4;
        cmd_y1    = 8'd4;
        cmd_color = CW'(5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_we", int'(we), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_din", int'(din), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_busy", int'(busy), 0);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].c, neg);
            check_vec(vecs[i], neg, $sformatf("vec%0d", i));
        end

        // Full screen, then a second command held pending on cmd_valid.
        clear_logs();
        c.x0 = 9'd0;
        c.y0 = 8'd0;
        c.x1 = 9'd319;
        c.y1 = 8'd239;
        c.color = CW'(5);
        issue(c, neg);
        cmd_x0    = 9'd10;
        cmd_y0    = 8'd20;
        cmd_x1    = 9'd12;
        cmd_y1    = 8'd22;
        cmd_color = CW'(11);
        wait_done(1, 80000);
        d = (done_cyc_q.size() >= 1) ? done_cyc_q[0] : 0;
        @(negedge clk);
        #1;
        chk("b2b_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("b2b_accepted", int'(busy), 1);
        wait_done(2, 1000);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        chk("full_nwrites", wr_addr_q.size(), 76800 + 9);
        chk("full_done_cyc", d - neg, 2 + 76800);
        if (wr_addr_q.size() == 76809) begin
            bad = 0;
            for (int i = 0; i < 76800; i++)
                if (wr_addr_q[i] != i || wr_cyc_q[i] != neg + 2 + i) bad++;
            chk("full_seq", bad, 0);
            chk("b2b_first_cyc", wr_cyc_q[76800] - d, 3);
            chk("b2b_first_addr", wr_addr_q[76800], 20 + 240 * 10);
        end
        bad = 0;
        for (int xx = 0; xx < WIDTH; xx++) begin
            for (int yy = 0; yy < HEIGHT; yy++) begin
                ex = (xx >= 10 && xx <= 12 && yy >= 20 && yy <= 22) ? 11 : 5;
                if (int'(ram[yy + HEIGHT * xx]) != ex) bad++;
            end
        end
        chk("ram_image", bad, 0);

        // Reset in the middle of a 10x240 fill.
        clear_logs();
        c.x0 = 9'd0;
        c.y0 = 8'd0;
        c.x1 = 9'd9;
        c.y1 = 8'd239;
        c.color = CW'(2);
        issue(c, neg);
        cmd_valid = 1'b0;
        d = 0;
        while (wr_addr_q.size() < 100 && d < 1000) begin
            @(negedge clk);
            #1;
            d++;
        end
        chk("abort_reach100", wr_addr_q.size(), 100);
        rst_n = 1'b0;
        #1;
        chk("abort_we", int'(we), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
        end
        chk("abort_writes", wr_addr_q.size(), 100);
        chk("abort_no_done", done_cyc_q.size(), 0);
        chk("abort_idle_ready", int'(cmd_ready), 1);
        if (wr_addr_q.size() == 100) chk("abort_last_addr", wr_addr_q[99], 99);
        run_cmd(vecs[1].c, neg);
        check_vec(vecs[1], neg, "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/background_fill.md
Name: background_fill

Overview:
- Write-side engine for the background frame RAM. Accepts rectangle-fill commands and streams one RAM write per cycle into the RAM's din/waddr/we write port.
- Sits between the scene/command logic and the background RAM. The background RAM's read side (x, y → dout) is untouched.
- Uses the RAM's column-major addressing: addr = y + HEIGHT*x.

Parameters:
- NUMBER_COLORS, 10, palette size; colour width CW = $clog2(NUMBER_COLORS)+1 (5 at default).
- WIDTH, 320, screen columns.
- HEIGHT, 240, screen rows; address width AW = $clog2(WIDTH*HEIGHT) (17 at default).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command (high only in IDLE).
- cmd_x0  in  9  left column, inclusive.
- cmd_y0  in  8  top row, inclusive.
- cmd_x1  in  9  right column, inclusive.
- cmd_y1  in  8  bottom row, inclusive.
- cmd_color  in  CW  fill colour index.
- we  out  1  RAM write enable, registered.
- waddr  out  AW  RAM write address, registered.
- din  out  CW  RAM write data, registered.
- busy  out  1  high in SETUP and FILL.
- done  out  1  one-cycle pulse when a command retires, including empty commands.

Behaviour:
- Reset: state IDLE; we=0, waddr=0, din=0, busy=0, done=0. cmd_ready=1 (state==IDLE), but no handshake is taken while rst_n=0.
- Handshake: a command is accepted on a rising edge with cmd_valid&&cmd_ready. All cmd_* fields are latched at that edge and may change afterwards.
- States:
  - IDLE→SETUP on accept.
  - SETUP→FILL if the rectangle is non-empty, else SETUP→DONE.
  - FILL→DONE after the last pixel is issued.
  - DONE→IDLE unconditionally; done=1 while in DONE.
- SETUP (1 cycle):
  - Clamp: x1c=min(x1,WIDTH-1), y1c=min(y1,HEIGHT-1).
  - Empty if x0>x1c, or y0>y1c, or x0>=WIDTH, or y0>=HEIGHT.
  - Compute base = y0 + HEIGHT*x0, which must fit in AW bits.
- FILL order: y inner (fastest), x outer, so addresses are contiguous within a column.
  - Within a column, waddr increments by 1.
  - At a column end, the next waddr = previous column's start + HEIGHT.
  - No multiplier in FILL: use incremental addressing only.
- Write timing:
  - we=1 for exactly (x1c-x0+1)*(y1c-y0+1) consecutive cycles.
  - First we=1 is the second cycle after the accept edge (accept edge → SETUP cycle → first write cycle).
  - din=latched colour throughout FILL.
- After the last write: we=0 and done=1 in the following cycle. cmd_ready returns to 1 the cycle after that.
- Empty command: no we pulses; done=1 the cycle after SETUP.
- waddr and din hold their last values when we=0.
- Back-to-back commands: minimum 3 non-write cycles between the last write of one command and the first write of the next (DONE, IDLE-accept, SETUP).
- Reset mid-FILL: we drops immediately (asynchronously) and the remaining pixels are abandoned. No done pulse is issued for the aborted command.
- Inputs with cmd_valid=0 are ignored in all states. cmd_valid during busy is not dropped; it stays pending until cmd_ready.

Decomposition:
- Shared package holds:
  - constants WIDTH=320, HEIGHT=240;
  - AW and CW derivation (colour width = clog2(NUMBER_COLORS)+1, matching the RAM);
  - FSM state encoding IDLE/SETUP/FILL/DONE.
- Sub-module bg_fill_addr_gen: x/y counters plus incremental column-major address register with load (base, bounds) and step inputs. The FSM lives in the top.

Test Plan:
- Single pixel: x0=x1=0, y0=y1=0, color=3 → exactly one we, waddr=0, din=3, then done pulse next cycle.
- 2x3 rectangle: x0=1, x1=2, y0=10, y1=12, color=7 → we on 6 consecutive cycles with waddr 250, 251, 252, 490, 491, 492; first write 2 cycles after accept.
- Clipping: x0=318, x1=400, y0=238, y1=255 → 4 writes: 76558, 76559, 76798, 76799.
- Empty: x0=5, x1=4 → zero we; done exactly one cycle after SETUP; cmd_ready high again the cycle after.
- Full screen then immediate second command (cmd_valid held high):
  - first command: 76800 writes, addresses 0..76799 strictly sequential;
  - second command accepted the cycle after done;
  - checker models the RAM and verifies every cell's colour.
- Reset mid-fill: assert rst_n=0 after 100 writes of a 10x240 fill → we=0 immediately, no done pulse. After release, cmd_ready=1 and a new command executes normally from SETUP.
